// File: rtl/result_writeback_queue_if.sv
// Handshake bundle between a VFU result producer, the writeback queue and the VRF bank arbiter.
// The queue uses the slave modport; the environment (VFU plus arbiter) uses the master modport.
interface result_writeback_queue_if #(
  parameter int AddrWidth = 9
);
  logic [63:0]          result_i;
  logic [AddrWidth-1:0] result_addr_i;
  logic [7:0]           result_be_i;
  logic [2:0]           result_id_i;
  logic                 result_valid_i;
  logic                 result_ready_o;
  logic                 wreq_o;
  logic                 wgnt_i;
  logic [63:0]          wdata_o;
  logic [AddrWidth-1:0] waddr_o;
  logic [7:0]           wbe_o;
  logic                 result_gnt_o;
  logic [2:0]           result_gnt_id_o;
  logic                 empty_o;

  // Result side: a transfer happens on result_valid_i && result_ready_o.
  // VRF side: wreq_o holds with a stable payload until wgnt_i; wgnt_i is ignored while wreq_o is low.
  modport slave (
    input  result_i, result_addr_i, result_be_i, result_id_i, result_valid_i, wgnt_i,
    output result_ready_o, wreq_o, wdata_o, waddr_o, wbe_o, result_gnt_o,
           result_gnt_id_o, empty_o
  );

  modport master (
    output result_i, result_addr_i, result_be_i, result_id_i, result_valid_i, wgnt_i,
    input  result_ready_o, wreq_o, wdata_o, waddr_o, wbe_o, result_gnt_o,
           result_gnt_id_o, empty_o
  );
endinterface

// File: rtl/result_writeback_queue.sv
// Circular FIFO buffering VFU results until the VRF bank arbiter grants a write.
// Optional feature: define ARA_RESULT_QUEUE_BYPASS_EN to let an empty queue forward results combinationally.
module result_writeback_queue #(
  parameter int NrLanes     = 4,
  parameter int BufferDepth = 2,
  parameter int AddrWidth   = 9
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  result_writeback_queue_if.slave bus
);

  localparam int CntW = $clog2(BufferDepth + 1);
  localparam int PtrW = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;

  if (BufferDepth < 1 || BufferDepth > 8) begin : g_bad_depth
    $error("result_writeback_queue: BufferDepth must be within 1..8");
  end
  if (NrLanes < 1) begin : g_bad_lanes
    $error("result_writeback_queue: NrLanes must be at least 1");
  end

  typedef struct packed {
    logic [63:0]          data;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           be;
    logic [2:0]           id;
  } entry_t;

  entry_t          mem [BufferDepth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic            gnt_q;
  logic [2:0]      gnt_id_q;

  entry_t in_entry, head, out_entry;
  logic   ready, empty, wreq, commit, push, fifo_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(BufferDepth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign in_entry = '{data: bus.result_i, addr: bus.result_addr_i,
                      be: bus.result_be_i, id: bus.result_id_i};
  assign head     = mem[rd_ptr];

  always_comb begin
    out_entry = '0;
    wreq      = 1'b0;
    ready     = (count != CntW'(BufferDepth));
    empty     = (count == '0);
    if (!empty) begin
      out_entry = head;
      wreq      = 1'b1;
    end
`ifdef ARA_RESULT_QUEUE_BYPASS_EN
    else if (bus.result_valid_i && rst_ni) begin
      out_entry = in_entry;
      wreq      = 1'b1;
    end
`endif
    commit   = wreq && bus.wgnt_i;
    fifo_pop = commit && !empty;
    push     = bus.result_valid_i && ready;
`ifdef ARA_RESULT_QUEUE_BYPASS_EN
    // A bypassed result granted in the same cycle never enters storage.
    if (empty && commit) push = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      gnt_q    <= 1'b0;
      gnt_id_q <= '0;
    end else begin
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, fifo_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      gnt_q    <= commit;
      gnt_id_q <= commit ? out_entry.id : 3'd0;
    end
  end

  assign bus.result_ready_o  = ready;
  assign bus.empty_o         = empty;
  assign bus.wreq_o          = wreq;
  assign bus.wdata_o         = out_entry.data;
  assign bus.waddr_o         = out_entry.addr;
  assign bus.wbe_o           = out_entry.be;
  assign bus.result_gnt_o    = gnt_q;
  assign bus.result_gnt_id_o = gnt_id_q;

endmodule

// File: tb/tb_result_writeback_queue.sv
// Bench for result_writeback_queue: two instances (depth 2 and depth 3) checked every cycle
// against a queue-based reference model; writes are scored in FIFO order from an expected queue.
module tb_result_writeback_queue;

  localparam int AW = 9;
  localparam int EW = 64 + AW + 8 + 3;
`ifdef ARA_RESULT_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [63:0]   data;
    logic [AW-1:0] addr;
    logic [7:0]    be;
    logic [2:0]    id;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_writeback_queue_if #(.AddrWidth(AW)) bus0 ();
  result_writeback_queue_if #(.AddrWidth(AW)) bus1 ();

  result_writeback_queue #(.NrLanes(4), .BufferDepth(2), .AddrWidth(AW)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));
  result_writeback_queue #(.NrLanes(4), .BufferDepth(3), .AddrWidth(AW)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

  // Applied inputs and observed outputs, indexed by instance.
  logic          in_v [2];
  logic [63:0]   in_d [2];
  logic [AW-1:0] in_a [2];
  logic [7:0]    in_b [2];
  logic [2:0]    in_i [2];
  logic          in_g [2];
  logic          o_ready [2], o_wreq [2], o_empty [2], o_gnt [2];
  logic [63:0]   o_wdata [2];
  logic [AW-1:0] o_waddr [2];
  logic [7:0]    o_wbe [2];
  logic [2:0]    o_gid [2];

  assign bus0.result_valid_i = in_v[0];
  assign bus0.result_i       = in_d[0];
  assign bus0.result_addr_i  = in_a[0];
  assign bus0.result_be_i    = in_b[0];
  assign bus0.result_id_i    = in_i[0];
  assign bus0.wgnt_i         = in_g[0];
  assign bus1.result_valid_i = in_v[1];
  assign bus1.result_i       = in_d[1];
  assign bus1.result_addr_i  = in_a[1];
  assign bus1.result_be_i    = in_b[1];
  assign bus1.result_id_i    = in_i[1];
  assign bus1.wgnt_i         = in_g[1];

  assign o_ready[0] = bus0.result_ready_o;  assign o_ready[1] = bus1.result_ready_o;
  assign o_wreq[0]  = bus0.wreq_o;          assign o_wreq[1]  = bus1.wreq_o;
  assign o_empty[0] = bus0.empty_o;         assign o_empty[1] = bus1.empty_o;
  assign o_gnt[0]   = bus0.result_gnt_o;    assign o_gnt[1]   = bus1.result_gnt_o;
  assign o_wdata[0] = bus0.wdata_o;         assign o_wdata[1] = bus1.wdata_o;
  assign o_waddr[0] = bus0.waddr_o;         assign o_waddr[1] = bus1.waddr_o;
  assign o_wbe[0]   = bus0.wbe_o;           assign o_wbe[1]   = bus1.wbe_o;
  assign o_gid[0]   = bus0.result_gnt_id_o; assign o_gid[1]   = bus1.result_gnt_id_o;

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q0 [$];
  logic [EW-1:0] exp_q1 [$];
  int            exp_size_now [2];
  logic          pend [2];
  logic [2:0]    pend_id [2];
  int            gnt_cnt [2];
  logic          acc [2];
  int            total = 0;
  int            bad = 0;

  function automatic int depth_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic q_push(input int d, input logic [EW-1:0] e);
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
  endtask

  function automatic logic [EW-1:0] q_front(input int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_pop(input int d);
    if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
  endtask

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h want=%h t=%0t", name, d, act, want, $time);
    end
  endtask

  task automatic chk_reset(input int d);
    check("rst_ready", d, 64'(o_ready[d]), 64'd1);
    check("rst_wreq",  d, 64'(o_wreq[d]),  64'd0);
    check("rst_empty", d, 64'(o_empty[d]), 64'd1);
    check("rst_gnt",   d, 64'(o_gnt[d]),   64'd0);
    check("rst_gid",   d, 64'(o_gid[d]),   64'd0);
    check("rst_wdata", d, o_wdata[d],      64'd0);
    check("rst_waddr", d, 64'(o_waddr[d]), 64'd0);
    check("rst_wbe",   d, 64'(o_wbe[d]),   64'd0);
  endtask

  // Monitor: compares every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    int   sz;
    logic ew;
    ent_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk_reset(d);
        pend[d] = 1'b0;
      end else begin
        sz = exp_size_now[d];
        ew = (sz != 0) || (BYP && in_v[d]);
        check("ready", d, 64'(o_ready[d]), 64'(sz != depth_of(d)));
        check("empty", d, 64'(o_empty[d]), 64'(sz == 0));
        check("wreq",  d, 64'(o_wreq[d]),  64'(ew));
        check("gnt",   d, 64'(o_gnt[d]),   64'(pend[d]));
        if (pend[d]) check("gnt_id", d, 64'(o_gid[d]), 64'(pend_id[d]));
        if (o_gnt[d]) gnt_cnt[d]++;
        if (ew && q_size(d) != 0) begin
          e = ent_t'(q_front(d));
          check("wdata", d, o_wdata[d],      e.data);
          check("waddr", d, 64'(o_waddr[d]), 64'(e.addr));
          check("wbe",   d, 64'(o_wbe[d]),   64'(e.be));
        end
        if (ew && in_g[d] && q_size(d) != 0) begin
          pend[d]    = 1'b1;
          pend_id[d] = e.id;
          q_pop(d);
        end else begin
          pend[d] = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic          nv [2];
  logic [63:0]   nd [2];
  logic [AW-1:0] na [2];
  logic [7:0]    nb [2];
  logic [2:0]    ni [2];
  logic          ng [2];

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      in_v[d] = nv[d]; in_d[d] = nd[d]; in_a[d] = na[d];
      in_b[d] = nb[d]; in_i[d] = ni[d]; in_g[d] = ng[d];
      exp_size_now[d] = q_size(d);
      acc[d] = nv[d] && (q_size(d) != depth_of(d));
      if (acc[d]) q_push(d, EW'({nd[d], na[d], nb[d], ni[d]}));
    end
  endtask

  task automatic set_payload(input int d, input logic [63:0] data, input logic [AW-1:0] addr,
                             input logic [7:0] be, input logic [2:0] id);
    nd[d] = data; na[d] = addr; nb[d] = be; ni[d] = id;
  endtask

  task automatic rand_payload(input int d);
    set_payload(d, {$urandom, $urandom}, AW'($urandom_range(0, 511)),
                8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
  endtask

  // Holds valid with a stable payload until accepted, optionally toggling the grant each cycle.
  task automatic push_hold(input int d, input bit toggle);
    int n;
    n = 0;
    nv[d] = 1'b1;
    do begin
      if (toggle) ng[d] = ~ng[d];
      step();
      n++;
    end while (!acc[d] && n < 20);
    nv[d] = 1'b0;
    if (!acc[d]) begin
      bad++;
      $display("FAIL push_timeout dut=%0d got=stalled want=accepted", d);
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    nv[d] = 1'b0;
    ng[d] = 1'b1;
    while ((q_size(d) != 0 || pend[d]) && n < 40) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      nv[d] = 1'b0; ng[d] = 1'b0; in_v[d] = 1'b0; in_g[d] = 1'b0;
      exp_size_now[d] = 0;
      pend[d] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
    #1;
    chk_reset(0);
    chk_reset(1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    for (int d = 0; d < 2; d++) begin
      nv[d] = 1'b0; ng[d] = 1'b0; set_payload(d, '0, '0, '0, '0);
      in_v[d] = 1'b0; in_g[d] = 1'b0; in_d[d] = '0; in_a[d] = '0; in_b[d] = '0; in_i[d] = '0;
      exp_size_now[d] = 0; pend[d] = 1'b0; pend_id[d] = '0; gnt_cnt[d] = 0; acc[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    step();

    // Single result with grant held: write one cycle later, gnt pulse after that.
    ng[0] = 1'b1;
    nv[0] = 1'b1;
    set_payload(0, 64'hDEAD_BEEF, AW'(5), 8'hFF, 3'd2);
    step();
    nv[0] = 1'b0;
    repeat (3) step();

    // Fill depth-2 queue with grant low; third push stalls; then full + pop refuses push.
    ng[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nv[0] = 1'b1;
      set_payload(0, 64'h1111_0000 + 64'(i), AW'(16 + i), 8'h0F, 3'(4 + i));
      step();
    end
    repeat (2) step();
    ng[0] = 1'b1;
    step();
    step();
    nv[0] = 1'b0;
    drain(0);

    // Stream of 10 with toggling grant.
    base = gnt_cnt[0];
    ng[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_payload(0);
      push_hold(0, 1'b1);
    end
    drain(0);
    check("gnt_pulses", 0, 64'(gnt_cnt[0] - base), 64'd10);

    // Reset while holding two entries.
    ng[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nv[0] = 1'b1;
      set_payload(0, 64'hBAD0_0000 + 64'(i), AW'(100 + i), 8'hAA, 3'(i));
      step();
    end
    nv[0] = 1'b0;
    step();
    do_reset();
    ng[0] = 1'b1;
    ng[1] = 1'b1;
    repeat (4) step();

    // Pointer wrap on depth-3 instance: 7 push/pop pairs.
    ng[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      nv[1] = 1'b1;
      rand_payload(1);
      step();
    end
    drain(1);

    // Random traffic on both instances; payload held while a push is stalled.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!(nv[d] && !acc[d])) begin
          nv[d] = 1'($urandom_range(0, 1));
          rand_payload(d);
        end
        ng[d] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    drain(0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_writeback_queue.md
RESULT_WRITEBACK_QUEUE -- requirements
Module: result_writeback_queue

Interface
REQ-001: Parameter NrLanes, default 4: number of lanes; informational, no effect on behaviour.
REQ-002: Parameter BufferDepth, default 2, legal range 1..8: number of FIFO entries.
REQ-003: Parameter AddrWidth, default 9: VRF byte-word address width.
REQ-004: clk_i  input  1  single clock, rising edge.
REQ-005: rst_ni  input  1  reset, asynchronous, active-low.
REQ-006: result_i  input  64  VFU result word (elen_t).
REQ-007: result_addr_i  input  AddrWidth  VRF destination address.
REQ-008: result_be_i  input  8  byte enables.
REQ-009: result_id_i  input  3  issuing instruction id.
REQ-010: result_valid_i  input  1  VFU result valid.
REQ-011: result_ready_o  output  1  queue can accept a result.
REQ-012: wreq_o  output  1  VRF write request.
REQ-013: wgnt_i  input  1  VRF write grant from bank arbiter.
REQ-014: wdata_o / waddr_o / wbe_o  output  64 / AddrWidth / 8  write payload.
REQ-015: result_gnt_o  output  1  one-cycle pulse: a result has been committed to the VRF.
REQ-016: result_gnt_id_o  output  3  id of the committed result; valid only while result_gnt_o is high.
REQ-017: empty_o  output  1  FIFO holds no entries.

Function
REQ-018: The queue SHALL store {data, addr, be, id} in a circular FIFO of BufferDepth entries, using read/write pointers that wrap from BufferDepth-1 to 0, and an occupancy counter of width $clog2(BufferDepth+1).
REQ-019: result_ready_o SHALL equal (count != BufferDepth). It is derived from the counter only, so a full queue does not accept a push even when a pop occurs in the same cycle.
REQ-020: A push SHALL occur on result_valid_i && result_ready_o. It writes the entry at the write pointer and increments that pointer.
REQ-021: wreq_o SHALL equal !empty_o. The payload outputs SHALL present the head entry and SHALL stay stable until wgnt_i is seen.
REQ-022: A pop SHALL occur on wreq_o && wgnt_i. wgnt_i SHALL be ignored while wreq_o is low.
REQ-023: A push and a pop in the same cycle SHALL leave count unchanged, and both pointers SHALL advance.
REQ-024: On each pop, result_gnt_o SHALL pulse high for exactly one cycle, one cycle after the pop, and result_gnt_id_o SHALL carry the popped id. Back-to-back pops SHALL give back-to-back pulses.
REQ-025: With the bypass feature disabled, the minimum latency from push to wreq_o SHALL be 1 cycle.
REQ-026: Results SHALL be written to the VRF in strict FIFO order, with no reordering by address or id.

Reset
REQ-027: While rst_ni is low, the pointers and count SHALL be 0 and the outputs SHALL be: result_ready_o=1, wreq_o=0, empty_o=1, result_gnt_o=0, all payload and id outputs 0.
REQ-028: Asserting reset mid-operation SHALL discard all stored entries and any pending result_gnt_o pulse. Storage contents need not be cleared.

Configuration
REQ-029: Macro ARA_RESULT_QUEUE_BYPASS_EN, when defined, SHALL enable bypass: while count==0 and result_valid_i=1, wreq_o SHALL assert combinationally and the payload SHALL come directly from the result inputs.
  - If wgnt_i=1 in that cycle, the result SHALL not be stored.
  - If wgnt_i=0, the result SHALL be pushed as normal.
  - result_gnt_o SHALL pulse on the next cycle either way.
REQ-030: When ARA_RESULT_QUEUE_BYPASS_EN is undefined, no combinational path SHALL exist from the result_* inputs to the w* outputs.

Verification
REQ-031: Reset, then push data=64'hDEAD_BEEF, addr=5, be=8'hFF, id=2 with wgnt_i=1 held.
  - Without bypass: wreq_o=1 on the next cycle, then result_gnt_o=1 with id=2 one cycle later.
  - With bypass: wreq_o=1 in the push cycle.
REQ-032: BufferDepth=2, wgnt_i=0, push 3 results back-to-back: ready_o drops after 2 pushes, the third is stalled, and wdata_o holds the first word.
REQ-033: With the queue full, assert valid and grant together: the pop occurs, the push is refused that cycle, and the push is accepted on the next cycle.
REQ-034: Stream 10 results with wgnt_i toggling 1/0: the VRF sees all 10 in order, each with its matching addr, be and id, and there are exactly 10 result_gnt_o pulses.
REQ-035: Drop rst_ni while holding 2 entries: empty_o=1, wreq_o=0 and result_gnt_o=0 immediately, and no stale write occurs after reset is released.
REQ-036: Pointer wrap, BufferDepth=3: 7 push/pop pairs keep data integrity across the wrap from index 2 to 0.
